// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Host-to-device PS/2 command transmitter. It sends one byte per request
//   on the open-drain PS/2 clock/data pair. An *_oe output of 1 pulls the
//   line low, and an *_oe output of 0 releases the line so it floats high.
//   Ports:
//     clk, rst            system clock, asynchronous active-high reset
//     tx_data, tx_valid   command byte and request (accepted when tx_ready)
//     tx_ready            high only when idle
//     kclk_i, kdata_i     PS/2 clock/data as seen at the pad (asynchronous)
//     kclk_oe, kdata_oe   registered pull-low enables for the pads
//     busy                high whenever a transfer is in progress
//     done                one-cycle pulse on device ACK
//     err                 one-cycle pulse on NACK or watchdog timeout
module ps2_host_transmitter #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int INH_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 1);
    localparam logic [CW-1:0] INH_PREV = CW'(INH_CYC - 2);
    localparam logic [CW-1:0] TO_LIM   = CW'(TO_CYC);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    frame_q, frame_d;   // {stop, parity, data[7:0]}
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;       // inhibit timer, then watchdog
    logic          ack_q, ack_d;
    logic          kclk_oe_q, kclk_oe_d;
    logic          kdata_oe_q, kdata_oe_d;

    // Pad synchronisers. They reset to 1 (idle bus) so that no false fall
    // is seen after reset.
    logic kclk_s1_q, kclk_s2_q, kclk_p_q;
    logic kdata_s1_q, kdata_s2_q;
    logic fall;

    assign fall = kclk_p_q & ~kclk_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_s1_q  <= 1'b1;
            kclk_s2_q  <= 1'b1;
            kclk_p_q   <= 1'b1;
            kdata_s1_q <= 1'b1;
            kdata_s2_q <= 1'b1;
        end else begin
            kclk_s1_q  <= kclk_i;
            kclk_s2_q  <= kclk_s1_q;
            kclk_p_q   <= kclk_s2_q;
            kdata_s1_q <= kdata_i;
            kdata_s2_q <= kdata_s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            kclk_oe_q  <= kclk_oe_d;
            kdata_oe_q <= kdata_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        ack_d      = ack_q;
        kclk_oe_d  = kclk_oe_q;
        kdata_oe_d = kdata_oe_q;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                cnt_d      = '0;
                bit_d      = '0;
                ack_d      = 1'b0;
                if (tx_valid) begin
                    frame_d    = {1'b1, ~^tx_data, tx_data};
                    kclk_oe_d  = 1'b1;
                    kdata_oe_d = (INH_CYC == 1);
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INH_LAST) begin
                    // Release the clock while still holding the start bit.
                    // The watchdog starts from zero in START.
                    cnt_d      = '0;
                    kclk_oe_d  = 1'b0;
                    kdata_oe_d = 1'b1;
                    state_d    = START;
                end else if (cnt_q == INH_PREV) begin
                    kdata_oe_d = 1'b1;
                end
            end
            default: begin
                // START/SHIFT/ACK/WAIT_IDLE run under the watchdog. A timeout
                // takes priority over a fall in the same cycle.
                cnt_d = fall ? '0 : cnt_q + 1'b1;
                if (cnt_q == TO_LIM) begin
                    err        = 1'b1;
                    cnt_d      = '0;
                    kclk_oe_d  = 1'b0;
                    kdata_oe_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    case (state_q)
                        START: if (fall) begin
                            kdata_oe_d = ~frame_q[0];
                            bit_d      = 4'd1;
                            state_d    = SHIFT;
                        end
                        SHIFT: if (fall) begin
                            // Bit 9 is the stop bit (1), so it is sent as a release.
                            kdata_oe_d = ~frame_q[bit_q];
                            bit_d      = bit_q + 4'd1;
                            if (bit_q == 4'd9) state_d = ACK;
                        end
                        ACK: begin
                            kdata_oe_d = 1'b0;
                            if (fall) begin
                                if (!kdata_s2_q) begin
                                    ack_d   = 1'b1;
                                    state_d = WAIT_IDLE;
                                end else begin
                                    err     = 1'b1;
                                    state_d = IDLE;
                                end
                            end
                        end
                        WAIT_IDLE: if (kclk_s2_q && kdata_s2_q && ack_q) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign kclk_oe  = kclk_oe_q;
    assign kdata_oe = kdata_oe_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter. A PS/2 device model shares the
// open-drain pads with the DUT. The model clocks at a 40-cycle period,
// samples data on rising edges, and ACKs or NACKs on the 11th clock.
module tb_ps2_host_transmitter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, kclk_oe, kdata_oe, busy, done, err;
    logic       dev_clk_low, dev_data_low;
    logic       kclk_pad, kdata_pad;

    assign kclk_pad  = ~(kclk_oe | dev_clk_low);
    assign kdata_pad = ~(kdata_oe | dev_data_low);

    ps2_host_transmitter #(
        .CLK_FREQ_HZ(50_000_000), .INHIBIT_US(2), .TIMEOUT_US(20)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .kclk_i(kclk_pad), .kdata_i(kdata_pad),
        .kclk_oe(kclk_oe), .kdata_oe(kdata_oe), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int kclk_hi = 0, done_cnt = 0, err_cnt = 0;
    int start_cyc = 0, err_cyc = 0, fall_cyc = 0;
    logic prev_kclk_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        kclk_hi      <= kclk_hi + int'(kclk_oe);
        done_cnt     <= done_cnt + int'(done);
        err_cnt      <= err_cnt + int'(err);
        prev_kclk_oe <= kclk_oe;
        if (prev_kclk_oe && !kclk_oe && kdata_oe) start_cyc <= cyc;
        if (err) err_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, then emit nfall clock pulses.
    // smp[0] is the start bit, and smp[10:1] are the bits read on rising edges.
    task automatic dev_xfer(input int nfall, input logic ack, output logic [10:0] smp);
        int t;
        smp = '0;
        t = 0;
        while (!(kclk_oe == 1'b0 && kdata_oe == 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        smp[0] = kdata_pad;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= nfall; i++) begin
            if (i == 11) begin
                dev_data_low = ack;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            fall_cyc    = cyc;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) smp[i] = kdata_pad;
            repeat (20) @(negedge clk);
        end
        if (nfall >= 11) begin
            repeat (5) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    // Wait for done/err, then capture the handshake and line state one cycle later.
    task automatic wait_pulse(input int lim, output logic d, output logic e,
                              output logic rdy, output logic kc, output logic kd);
        logic seen;
        seen = 1'b0; d = 1'b0; e = 1'b0; rdy = 1'b0; kc = 1'b1; kd = 1'b1;
        for (int t = 0; t < lim; t++) begin
            @(negedge clk);
            if (done || err) begin
                d = done; e = err; seen = 1'b1;
                break;
            end
        end
        chk("pulse_seen", 32'(seen), 1);
        if (seen) begin
            @(negedge clk);
            rdy = tx_ready; kc = kclk_oe; kd = kdata_oe;
        end
    endtask

    task automatic run_ok(input string tag, input logic [7:0] b, input logic [10:0] exp_frame);
        logic [10:0] smp;
        logic gd, ge, rdy, kc, kd;
        int kh0, d0, e0;
        kh0 = kclk_hi; d0 = done_cnt; e0 = err_cnt;
        send(b);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_rdy_lo"}, 32'(tx_ready), 0);
        fork
            dev_xfer(11, 1'b1, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk({tag, "_frame"}, 32'(smp), 32'(exp_frame));
        chk({tag, "_done"}, 32'(gd), 1);
        chk({tag, "_err"}, 32'(ge), 0);
        chk({tag, "_rdy_after"}, 32'(rdy), 1);
        chk({tag, "_inh_cyc"}, 32'(kclk_hi - kh0), 100);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 1);
        chk({tag, "_err_cnt"}, 32'(err_cnt - e0), 0);
    endtask

    initial begin
        logic [10:0] smp;
        logic gd, ge, rdy, kc, kd;
        int d0, e0, t;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_kclk_oe", 32'(kclk_oe), 0);
        chk("rst_kdata_oe", 32'(kdata_oe), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(tx_ready), 1);

        // Normal transfers; frames are {stop, parity, data, start}.
        run_ok("ed", 8'hED, 11'b1_1_11101101_0);
        run_ok("01", 8'h01, 11'b1_0_00000001_0);
        run_ok("ff", 8'hFF, 11'b1_1_11111111_0);
        run_ok("00", 8'h00, 11'b1_1_00000000_0);

        // NACK on the 11th clock.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h55);
        fork
            dev_xfer(11, 1'b0, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk("nack_err", 32'(ge), 1);
        chk("nack_done", 32'(gd), 0);
        chk("nack_kclk_oe", 32'(kc), 0);
        chk("nack_kdata_oe", 32'(kd), 0);
        chk("nack_ready", 32'(rdy), 1);
        chk("nack_err_cnt", 32'(err_cnt - e0), 1);
        chk("nack_done_cnt", 32'(done_cnt - d0), 0);

        // The device never clocks after the inhibit.
        send(8'hFF);
        fork
            dev_xfer(0, 1'b1, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk("to0_err", 32'(ge), 1);
        chk("to0_delay", 32'(err_cyc - start_cyc), 1000);
        chk("to0_kclk_oe", 32'(kc), 0);
        chk("to0_kdata_oe", 32'(kd), 0);
        chk("to0_ready", 32'(rdy), 1);

        // The device stops after five clocks. Fall detection adds 2-3 cycles.
        send(8'hED);
        fork
            dev_xfer(5, 1'b1, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk("to5_err", 32'(ge), 1);
        chk("to5_delay", 32'((err_cyc - fall_cyc) >= 1002 && (err_cyc - fall_cyc) <= 1004), 1);
        chk("to5_released", 32'({kc, kd}), 0);

        // Reset pulse in the middle of SHIFT.
        send(8'hED);
        fork
            dev_xfer(11, 1'b1, smp);
            begin
                t = 0;
                while (!(kclk_oe == 1'b0 && kdata_oe == 1'b1) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                repeat (100) @(negedge clk);
                chk("mid_busy", 32'(busy), 1);
                d0 = done_cnt; e0 = err_cnt;
                #2 rst = 1'b1;
                #1;
                chk("mid_rst_kclk_oe", 32'(kclk_oe), 0);
                chk("mid_rst_kdata_oe", 32'(kdata_oe), 0);
                chk("mid_rst_busy", 32'(busy), 0);
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
        chk("mid_rst_no_err", 32'(err_cnt - e0), 0);
        run_ok("f4", 8'hF4, 11'b1_0_11110100_0);

        // Hold tx_valid high while busy, with a new byte presented.
        d0 = done_cnt;
        @(negedge clk);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        chk("hold_rdy_lo", 32'(tx_ready), 0);
        tx_data = 8'hA5;
        fork
            dev_xfer(11, 1'b1, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk("hold_frame1", 32'(smp), 32'(11'b1_1_00111100_0));
        chk("hold_one_done", 32'(done_cnt - d0), 1);
        chk("hold_rdy_after", 32'(rdy), 1);
        @(negedge clk);
        chk("hold_second_accept", 32'(busy), 1);
        tx_valid = 1'b0;
        fork
            dev_xfer(11, 1'b1, smp);
            wait_pulse(3000, gd, ge, rdy, kc, kd);
        join
        chk("hold_frame2", 32'(smp), 32'(11'b1_1_10100101_0));
        chk("hold_done2", 32'(gd), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
